matmul_job_arbiter: RTL and testbench
=====================================

# matmul_job_arbiter

Shares one matrix-multiply engine (naive or systolic, same start/done contract) among NUM_REQ requesters. Grants jobs round-robin, issues a single-cycle start pulse to the engine, and waits for done or a timeout. It then acknowledges the owning requester and records the job's cycle count. It sits between the host-side job sources and the engine's start/done pins, replacing direct testbench pulsing of start.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- ID_W, $clog2(NUM_REQ): width of grant_id
- CNT_W, 32: width of cycle counter and last_cycles
- TIMEOUT_CYCLES, 1<<20: RUN cycles before a job is aborted; must be ≥2

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level job request per requester, held until its ack
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- eng_start  out  1  one-cycle start pulse to the engine
- eng_done  in  1  engine done, level; may stay high after completion
- busy  out  1  high in every state except IDLE
- grant_id  out  ID_W  index of the current or most recent owner
- last_cycles  out  CNT_W  RUN-cycle count of the most recently finished job
- timeout_err  out  1  one-cycle pulse, coincident with ack, when a job timed out

## Operation
- States: IDLE → START → RUN → DONE → IDLE.
- IDLE:
  - If any req bit is high, select the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register that index into grant_id and go to START.
  - Otherwise stay in IDLE.
- START:
  - eng_start = 1 for exactly this cycle.
  - Clear count to 0 and go to RUN unconditionally.
  - eng_done is ignored in this state, so a stale done from the previous job is masked.
- RUN:
  - count increments each cycle, saturating at its maximum.
  - If eng_done is sampled high: last_cycles ← count+1, to_flag ← 0, go to DONE.
  - Otherwise, if count+1 == TIMEOUT_CYCLES: last_cycles ← TIMEOUT_CYCLES, to_flag ← 1, go to DONE.
  - If both conditions hold on the same cycle, done wins and no timeout is flagged.
- DONE:
  - ack[grant_id] = 1 and timeout_err = to_flag for this cycle only.
  - rr_ptr ← (grant_id+1) mod NUM_REQ. Go to IDLE.
- Requester contract: drop req in the cycle after ack. If req is still high when IDLE samples it, that is a new job.
- Requests that change while a job is in flight have no effect until IDLE.
- Round-robin guarantee: no requester waits more than NUM_REQ−1 jobs.
- Reset, whether idle or mid-job:
  - state = IDLE, rr_ptr = 0, count = 0.
  - All outputs go to 0: ack, eng_start, busy, grant_id, last_cycles, timeout_err.
  - No ack is issued for an aborted job. The engine must share the same reset.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- req sampled at edge E (in IDLE):
  - eng_start and busy go high in cycle E+1.
  - RUN begins at E+2.
- eng_done sampled high at the edge ending the Nth RUN cycle: ack, last_cycles = N, and timeout_err (if set) appear in the following cycle.
- Back-to-back jobs: the minimum idle gap is one cycle (IDLE) between ack and the next eng_start+1.
- Minimum job length is 1 RUN cycle, i.e. done is seen on the first RUN edge. Full arbitration overhead is 3 cycles (IDLE, START, DONE) per job.

## Structure
- Shared package matmul_pkg:
  - state enum {IDLE, START, RUN, DONE}
  - default CNT_W and TIMEOUT_CYCLES constants
  - an id-width helper, reused by the engine benches
- Sub-module rr_arbiter (NUM_REQ, ID_W):
  - inputs req and ptr; outputs any and idx
  - purely combinational, first set bit at or after ptr with wrap
- The top-level FSM, counter and output registers live in matmul_job_arbiter.

## Test plan
- Single requester: req[2]=1, engine model raises done in RUN cycle 7 → one eng_start pulse, ack=4'b0100 one cycle, last_cycles=7, timeout_err=0, grant_id=2.
- Round-robin: req=4'b1111 held (each requester re-raises req after its ack), engine done after 3 cycles → grant order 0,1,2,3,0; each ack one cycle; eng_start pulses 6 cycles apart.
- Stale done: eng_done held high continuously → every job completes with last_cycles=1; no job is skipped and no double ack.
- Timeout: TIMEOUT_CYCLES=16, eng_done never rises → ack and timeout_err pulse together with last_cycles=16; the next requester is granted normally. Also check done and timeout on the same edge → timeout_err=0.
- Reset mid-job: assert rst in RUN cycle 4 → all outputs 0 immediately (async), no ack afterwards. After release, req[0] is served with a fresh count and rr_ptr=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply job arbiter and engine benches.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1 << 20;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import matmul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_REQ-1:0] rot;
  int unsigned          sum;

  // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    any = 1'b0;
    idx = '0;
    sum = 0;
    rot = {req, req} >> ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = 32'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx = ID_W'(sum);
      end
    end
  end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Round-robin job arbiter sharing one matmul engine across NUM_REQ requesters.
module matmul_job_arbiter
  import matmul_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = id_width(NUM_REQ),
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic [CNT_W-1:0]   last_cycles,
  output logic               timeout_err
);

  localparam logic [CNT_W:0] TMO = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t             state, state_n;
  logic [ID_W-1:0]    rr_ptr, ptr_n, grant_n;
  logic [CNT_W-1:0]   count, count_n, count_sat, last_n;
  logic [CNT_W:0]     count_p1;
  logic               to_flag, to_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               arb_any;
  logic [ID_W-1:0]    arb_idx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req(req),
    .ptr(rr_ptr),
    .any(arb_any),
    .idx(arb_idx)
  );

  assign count_p1  = {1'b0, count} + (CNT_W+1)'(1);
  assign count_sat = (&count) ? count : count_p1[CNT_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and next-value logic for the datapath registers.
  always_comb begin
    state_n = state;
    count_n = count;
    last_n  = last_cycles;
    to_n    = to_flag;
    grant_n = grant_id;
    ptr_n   = rr_ptr;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          grant_n = arb_idx;
          state_n = START;
        end
      end
      START: begin
        count_n = '0;
        state_n = RUN;
      end
      RUN: begin
        count_n = count_sat;
        if (eng_done) begin
          last_n  = count_sat;
          to_n    = 1'b0;
          state_n = DONE;
        end else if (count_p1 == TMO) begin
          last_n  = TMO[CNT_W-1:0];
          to_n    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ptr_n   = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ack_n = '0;
    if (state_n == DONE) ack_n[grant_n] = 1'b1;
  end

  // Outputs are decoded from the next state so they appear registered in the matching cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      count       <= '0;
      to_flag     <= 1'b0;
      grant_id    <= '0;
      last_cycles <= '0;
      ack         <= '0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rr_ptr      <= ptr_n;
      count       <= count_n;
      to_flag     <= to_n;
      grant_id    <= grant_n;
      last_cycles <= last_n;
      ack         <= ack_n;
      eng_start   <= (state_n == START);
      busy        <= (state_n != IDLE);
      timeout_err <= (state_n == DONE) && to_n;
    end
  end

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Self-checking bench for matmul_job_arbiter with a behavioural engine and arbitration model.
module tb_matmul_job_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            eng_start;
  logic            eng_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic [31:0]     last_cycles;
  logic            timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ptr_m  = 0;     // model of the round-robin pointer
  int lat_cfg = 0;    // engine latency for the next job, 0 = never finishes
  bit hold_done = 0;  // engine holds done high permanently

  matmul_job_arbiter #(
    .NUM_REQ       (NREQ),
    .ID_W          (2),
    .CNT_W         (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .last_cycles(last_cycles),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done is raised during RUN cycle lat (counted from the start pulse).
  initial begin
    int run_k;
    int lat_cur;
    bit active;
    run_k = 0; lat_cur = 0; active = 0;
    eng_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        eng_done = hold_done;
      end else if (hold_done) begin
        eng_done = 1;
      end else if (eng_start) begin
        active = 1; run_k = 0; lat_cur = lat_cfg; eng_done = 0;
      end else if (active) begin
        run_k++;
        eng_done = (lat_cur != 0 && run_k == lat_cur);
        if (eng_done) active = 0;
      end else begin
        eng_done = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1;
    ptr_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Runs one job end to end from the current req vector, checking every phase.
  task automatic serve(input int lat, output int g, output int t_start);
    int exp_g, exp_last, exp_to, n;
    bit seen;
    lat_cfg = lat;
    g = -1; t_start = 0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (eng_start === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_wait: no eng_start seen, req=%b", req);
      return;
    end
    exp_g = pick(req, ptr_m);
    t_start = cyc;
    g = int'(grant_id);
    checks++;
    if (grant_id !== 2'(exp_g) || busy !== 1'b1 || ack !== '0) begin
      errors++;
      $display("FAIL grant: grant_id=%0d busy=%b ack=%b, expected grant %0d busy 1 ack 0", grant_id, busy, ack, exp_g);
    end
    if (hold_done)                      begin exp_last = 1;   exp_to = 0; end
    else if (lat >= 1 && lat <= TMO)    begin exp_last = lat; exp_to = 0; end
    else                                begin exp_last = TMO; exp_to = 1; end
    n = 0; seen = 0;
    while (!seen && n < TMO + 8) begin
      @(negedge clk);
      n++;
      if (ack !== '0) seen = 1;
      else begin
        checks++;
        if (eng_start !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL run_phase: eng_start=%b busy=%b timeout_err=%b, expected 0 1 0", eng_start, busy, timeout_err);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_wait: no ack within %0d cycles", n);
      return;
    end
    checks++;
    if (ack !== NREQ'(1 << exp_g)) begin
      errors++;
      $display("FAIL ack: ack=%b expected %b", ack, NREQ'(1 << exp_g));
    end
    checks++;
    if (last_cycles !== 32'(exp_last) || timeout_err !== 1'(exp_to)) begin
      errors++;
      $display("FAIL result: last_cycles=%0d timeout_err=%b expected %0d %0d", last_cycles, timeout_err, exp_last, exp_to);
    end
    checks++;
    if (n != exp_last + 1) begin
      errors++;
      $display("FAIL latency: start-to-ack %0d cycles expected %0d", n, exp_last + 1);
    end
    req[exp_g] = 1'b0;
    ptr_m = (exp_g + 1) % NREQ;
    @(negedge clk);
    checks++;
    if (ack !== '0 || timeout_err !== 1'b0 || busy !== 1'b0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap: ack=%b timeout_err=%b busy=%b eng_start=%b expected all 0", ack, timeout_err, busy, eng_start);
    end
  endtask

  task automatic test_reset();
    rst = 1; req = '0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || eng_start !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 ||
        last_cycles !== 32'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack=%b start=%b busy=%b grant=%0d last=%0d to=%b expected all 0",
               ack, eng_start, busy, grant_id, last_cycles, timeout_err);
    end
    @(negedge clk);
    rst = 0;
    ptr_m = 0;
  endtask

  task automatic test_single();
    int g, ts;
    req = 4'b0100;
    serve(7, g, ts);
    checks++;
    if (g != 2) begin
      errors++;
      $display("FAIL single_grant: grant_id=%0d expected 2", g);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int g, ts, prev;
    apply_reset();
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      serve(3, g, ts);
      checks++;
      if (g != order[i]) begin
        errors++;
        $display("FAIL rr_order: job %0d grant_id=%0d expected %0d", i, g, order[i]);
      end
      if (i > 0) begin
        checks++;
        if (ts - prev != 6) begin
          errors++;
          $display("FAIL rr_spacing: start spacing %0d expected 6", ts - prev);
        end
      end
      prev = ts;
      if (g >= 0) req[g] = 1'b1;
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    int g, ts;
    hold_done = 1;
    req = 4'b0110;
    serve(5, g, ts);
    serve(5, g, ts);
    req = 4'b1000;
    serve(5, g, ts);
    checks++;
    if (g != 3) begin
      errors++;
      $display("FAIL stale_grant: grant_id=%0d expected 3", g);
    end
    hold_done = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int g, ts;
    req = 4'b1010;
    serve(0, g, ts);
    serve(4, g, ts);
    req = 4'b0001;
    serve(TMO, g, ts);
  endtask

  task automatic test_random();
    int g, ts;
    for (int j = 0; j < 30; j++) begin
      req = req | 4'($urandom_range(0, 15));
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      serve($urandom_range(0, 20), g, ts);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    int g, ts;
    bit seen, bad;
    lat_cfg = 0;
    req = 4'b0010;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (eng_start === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midreset_start: no eng_start seen");
    end
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (ack !== '0 || eng_start !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 ||
        last_cycles !== 32'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: ack=%b start=%b busy=%b grant=%0d last=%0d to=%b expected all 0",
               ack, eng_start, busy, grant_id, last_cycles, timeout_err);
    end
    ptr_m = 0;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (ack !== '0 || eng_start !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_quiet: activity seen after reset with no requests, ack=%b busy=%b", ack, busy);
    end
    req = 4'b1001;
    serve(5, g, ts);
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL midreset_grant: grant_id=%0d expected 0", g);
    end
  endtask

  initial begin
    rst = 1;
    req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_random();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
